// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Memory-stage data access engine. Turns EX/MEM load/store
//             control into one outstanding data-bus request, formats read
//             data for MEM/WB, stalls the pipeline while the bus is busy and
//             flags misaligned accesses and bus timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   load_q, load_d;
  logic          align_q, align_d;
  logic          berr_q, berr_d;
  // Access attributes captured at issue; read data is formatted with these
  // because EX/MEM may legally change once the bus is owned.
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          sign_q, sign_d;

  logic          w_acc;
  logic          w_mis;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_fmt;

  assign w_acc = mem_rd | mem_wr;

  // Misalignment check on the incoming access.
  always_comb begin
    w_mis = 1'b0;
    case (mem_size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = addr[0];
      default: w_mis = (addr[1:0] != 2'b00);
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (mem_size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  // Lane select and sign/zero extension of returning read data.
  always_comb begin
    w_byte = bus_rdata[7:0];
    case (off_q)
      2'd0: w_byte = bus_rdata[7:0];
      2'd1: w_byte = bus_rdata[15:8];
      2'd2: w_byte = bus_rdata[23:16];
      2'd3: w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   w_fmt = {{24{sign_q & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{16{sign_q & w_half[15]}}, w_half};
      default: w_fmt = bus_rdata;
    endcase
  end

  // Pipeline hold: an aligned access in IDLE stalls immediately so the
  // instruction stays put until its DONE cycle.
  assign stall = ((state_q == IDLE) & w_acc & ~w_mis) | (state_q == BUSY);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    load_d  = load_q;
    off_d   = off_q;
    size_d  = size_q;
    sign_d  = sign_q;
    align_d = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_acc) begin
          if (w_mis) begin
            align_d = 1'b1;
            load_d  = 32'h0;
          end else begin
            addr_d  = {addr[31:2], 2'b00};
            we_d    = mem_wr;
            be_d    = w_be;
            wdata_d = w_wdata;
            off_d   = addr[1:0];
            size_d  = mem_size;
            sign_d  = mem_sign;
            req_d   = 1'b1;
            cnt_d   = CW'(1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          load_d  = we_q ? 32'h0 : w_fmt;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          load_d  = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // One idle-ahead cycle so the retiring instruction is not reissued.
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      load_q  <= 32'h0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      align_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      load_q  <= load_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      align_q <= align_d;
      berr_q  <= berr_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign load_data = load_q;
  assign align_err = align_q;
  assign bus_err   = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit with a
//             load-data scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] load_data;
  logic        stall;
  logic        align_err;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_size  (mem_size),
    .mem_sign  (mem_sign),
    .addr      (addr),
    .wdata     (wdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .load_data (load_data),
    .stall     (stall),
    .align_err (align_err),
    .bus_err   (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one aligned access, acks it in BUSY cycle ack_at (0 = never),
  // checks the bus fields and the scoreboarded load result in DONE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat,
                        input logic [31:0] e_addr, input logic e_we,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input int e_req, input logic e_berr,
                        input logic [31:0] e_load);
    int  req_cnt;
    bit  done;
    logic [31:0] e;
    req_cnt = 0;
    done    = 1'b0;
    exp_q.push_back(e_load);
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; mem_size = sz; mem_sign = sg; addr = a; wdata = wd;
    #1;
    chk({tag, "_stall_issue"}, 32'(stall), 32'd1);
    for (int c = 1; c <= TIMEOUT + 4 && !done; c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          chk({tag, "_bus_addr"},  bus_addr, e_addr);
          chk({tag, "_bus_we"},    32'(bus_we), 32'(e_we));
          chk({tag, "_bus_be"},    32'(bus_be), 32'(e_be));
          chk({tag, "_bus_wdata"}, bus_wdata, e_wdata);
        end
        if (req_cnt == ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = rdat;
        end
        #1;
        chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
      end else begin
        done = 1'b1;
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_bus_err"},    32'(bus_err), 32'(e_berr));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_load_data"}, load_data, e);
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_no_done observed=busy expected=done", tag);
    end
    chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(e_req));
    @(negedge clk);
    #1;
    chk({tag, "_idle_req"},   32'(bus_req), 32'd0);
    chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
    chk({tag, "_idle_berr"},  32'(bus_err), 32'd0);
  endtask

  initial begin
    rst = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'b00; mem_sign = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(bus_req), 32'd0);
    chk("rst_addr",  bus_addr, 32'h0);
    chk("rst_be",    32'(bus_be), 32'd0);
    chk("rst_load",  load_data, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_aerr",  32'(align_err), 32'd0);
    chk("rst_berr",  32'(bus_err), 32'd0);
    rst = 1'b1;

    // LW 0x100, ack in second BUSY cycle
    access("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF,
           32'h100, 0, 4'b1111, 32'h0, 2, 0, 32'hDEADBEEF);

    // Reset in the middle of BUSY
    @(negedge clk);
    mem_rd = 1'b1; mem_size = 2'b10; addr = 32'h300;
    @(negedge clk);
    chk("mrst_busy_req", 32'(bus_req), 32'd1);
    rst = 1'b0; mem_rd = 1'b0;
    @(negedge clk);
    chk("mrst_req",   32'(bus_req), 32'd0);
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_load",  load_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_idle_req",   32'(bus_req), 32'd0);
    chk("mrst_idle_stall", 32'(stall), 32'd0);

    // LB signed / unsigned at 0x103
    access("lb_s", 1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h80FF0011,
           32'h100, 0, 4'b1000, 32'h0, 1, 0, 32'hFFFFFF80);
    access("lb_u", 1, 0, 2'b00, 0, 32'h103, 32'h0, 3, 32'h80FF0011,
           32'h100, 0, 4'b1000, 32'h0, 3, 0, 32'h00000080);

    // SH 0x22
    access("sh", 0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 1, 32'hFFFFFFFF,
           32'h20, 1, 4'b1100, 32'hABCDABCD, 1, 0, 32'h0);

    // LH signed upper half, LBU lane 1
    access("lh_s", 1, 0, 2'b01, 1, 32'h102, 32'h0, 2, 32'h80017FFF,
           32'h100, 0, 4'b1100, 32'h0, 2, 0, 32'hFFFF8001);
    access("lbu1", 1, 0, 2'b00, 0, 32'h101, 32'h0, 1, 32'h0000A500,
           32'h100, 0, 4'b0010, 32'h0, 1, 0, 32'h000000A5);

    // rd and wr together: store wins
    access("sb_both", 1, 1, 2'b00, 1, 32'h3, 32'hCAFE0055, 1, 32'h12345678,
           32'h0, 1, 4'b1000, 32'h55555555, 1, 0, 32'h0);

    // Size 11 behaves as word; leaves a nonzero load_data behind
    access("lw11", 1, 0, 2'b11, 0, 32'h44, 32'h0, 1, 32'h13579BDF,
           32'h44, 0, 4'b1111, 32'h0, 1, 0, 32'h13579BDF);

    // Misaligned LW 0x102
    @(negedge clk);
    mem_rd = 1'b1; mem_size = 2'b10; addr = 32'h102;
    #1;
    chk("mis_stall_issue", 32'(stall), 32'd0);
    @(negedge clk);
    mem_rd = 1'b0;
    #1;
    chk("mis_aerr",  32'(align_err), 32'd1);
    chk("mis_req",   32'(bus_req), 32'd0);
    chk("mis_load",  load_data, 32'h0);
    chk("mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("mis_aerr_pulse", 32'(align_err), 32'd0);
    chk("mis_req2",       32'(bus_req), 32'd0);

    // Misaligned half 0x201
    mem_rd = 1'b1; mem_size = 2'b01; addr = 32'h201;
    @(negedge clk);
    mem_rd = 1'b0;
    chk("mish_aerr", 32'(align_err), 32'd1);
    chk("mish_req",  32'(bus_req), 32'd0);

    // Reload something nonzero before the timeout case
    access("lw_pre", 1, 0, 2'b10, 0, 32'h80, 32'h0, 1, 32'hA5A5A5A5,
           32'h80, 0, 4'b1111, 32'h0, 1, 0, 32'hA5A5A5A5);

    // Timeout: no ack at all
    access("tmo", 1, 0, 2'b10, 0, 32'h200, 32'h0, 0, 32'h0,
           32'h200, 0, 4'b1111, 32'h0, TIMEOUT, 1, 32'h0);

    // Late ack while IDLE has no effect
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("late_load",  load_data, 32'h0);
    chk("late_req",   32'(bus_req), 32'd0);
    chk("late_stall", 32'(stall), 32'd0);
    chk("late_berr",  32'(bus_err), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage data access engine between the EX/MEM pipeline register and MEM/WB. It turns load/store control from EX/MEM into a single-outstanding request on the data-memory bus.
- Aligns and extends read data, and produces memData for MEM/WB.
- Holds the pipeline (`stall`) while the bus is busy. MEM/WB write is driven by `~stall`.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: max BUSY cycles waiting for bus_ack before aborting (≥2).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low (rst==0 at posedge clk resets)
- mem_rd  in  1  load request from EX/MEM
- mem_wr  in  1  store request from EX/MEM
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_sign  in  1  1 = sign-extend byte/half loads, 0 = zero-extend
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rt value)
- bus_req  out  1  request valid, held until ack/timeout
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion pulse
- load_data  out  32  aligned/extended load result to MEM/WB memData
- stall  out  1  1 = hold upstream stages and MEM/WB
- align_err  out  1  one-cycle pulse, misaligned access
- bus_err  out  1  one-cycle pulse, timeout

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, wait counter=0, all registered outputs 0 (bus_req, bus_we, bus_addr, bus_wdata, bus_be, load_data, align_err, bus_err). This applies mid-transaction: bus_req drops at that edge.
- States: IDLE, BUSY, DONE.
- acc = mem_rd|mem_wr. If both are 1, the access is a store (mem_wr wins).
- Misaligned when:
  - size 01 and addr[0]==1, or
  - size 10/11 and addr[1:0]!=0.
- stall (combinational) = (IDLE & acc & ~misaligned) | BUSY. stall is 0 in DONE.
- IDLE:
  - acc & misaligned: no bus activity, align_err=1 for the next cycle, load_data=0, stay IDLE.
  - acc & aligned: register bus_addr/bus_we/bus_be/bus_wdata, set bus_req=1, counter=1, go BUSY.
  - no acc: stay IDLE.
- BUSY:
  - bus_req held with bus fields stable.
  - bus_ack=1: bus_req=0, go DONE. For a load, load_data = formatted bus_rdata. For a store, load_data = 0.
  - counter==TIMEOUT and no ack: bus_req=0, bus_err pulse, load_data=0, go DONE.
  - Otherwise counter+1.
- DONE: stall=0, so upstream and MEM/WB advance at this edge. Go IDLE unconditionally. This one cycle prevents the same instruction from reissuing.
- bus_ack in IDLE/DONE is ignored.
- Access latency: ack in the k-th BUSY cycle → memData valid in DONE, which is k+1 cycles after the IDLE issue cycle. Minimum is 3 cycles: issue, BUSY with ack, DONE.
- Byte enables:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}
  - word: be = 1111, wdata unchanged
- Load formatting:
  - byte: lane rdata[8*addr[1:0] +: 8]
  - half: lane rdata[16*addr[1] +: 16]
  - Extension per mem_sign. Uses addr[1:0] registered at issue.
- load_data holds its value except at the update points above. It is not cleared in DONE→IDLE.

Test Plan:
- Reset: rst=0 for 2 cycles during BUSY → bus_req=0, stall=0, load_data=0, state IDLE next cycle.
- LW addr=0x100, ack after 2 BUSY cycles with rdata=0xDEADBEEF:
  - bus_addr=0x100, be=1111
  - stall=1 for 3 cycles, then 0 in DONE
  - load_data=0xDEADBEEF
- LB signed addr=0x103, rdata=0x80FF_0011 → be=1000, load_data=0xFFFFFF80. Unsigned (mem_sign=0) → 0x00000080.
- SH addr=0x22, wdata=0x1234ABCD → bus_we=1, bus_addr=0x20, be=1100, bus_wdata=0xABCDABCD, load_data=0 after ack.
- LW addr=0x102 → no bus_req, align_err=1 for one cycle, stall=0 throughout.
- LW with no ack (TIMEOUT=16) → bus_req high for exactly 16 cycles, bus_err pulse, load_data=0, DONE then IDLE. A late ack in IDLE has no effect.
